// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot/access controller.
// Holds the controller state encoding and the imem geometry.
package imem_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_DBG     = 3'd4
  } imem_ctrl_state_t;

  localparam int          IMEM_DEPTH = 64;
  localparam int          IMEM_AW    = 6;
  localparam int          IMEM_DW    = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h00000000;

endpackage

// File: rtl/imem_boot_ctrl.sv
// Boot loader and read-port arbiter for the MIPS instruction memory: streams a
// program into imem while the core is held in reset, then shares the read port with debug reads.
module imem_boot_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = IMEM_AW,
  parameter int DW    = IMEM_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          s_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_wa,
  output logic [DW-1:0] imem_wd,
  output logic [AW-1:0] imem_a,
  input  logic [DW-1:0] imem_rd,
  input  logic [AW-1:0] pc_addr,
  output logic [DW-1:0] instr,
  output logic          cpu_reset,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  output logic          done,
  output logic          ovf,
  output logic [AW:0]   word_count
);

  // Stream handshake: a beat transfers on a rising edge where s_valid and
  // s_ready are both high; s_ready is high for the whole LOAD state.

  imem_ctrl_state_t state, next_state;
  logic [AW-1:0]    addr_cnt;
  logic             load_go;
  logic             beat;
  logic             at_end;
  logic             dbg_go;

  assign at_end = (addr_cnt == AW'(DEPTH - 1));
  assign beat   = (state == ST_LOAD) && s_valid;
  // A request still held high during its ack cycle must not start a second read.
  assign dbg_go = dbg_req && !dbg_ack;

  always_comb begin
    next_state = state;
    load_go    = 1'b0;
    cpu_reset  = 1'b1;
    cpu_stall  = 1'b0;
    s_ready    = 1'b0;
    imem_we    = 1'b0;
    imem_wa    = '0;
    imem_wd    = '0;
    imem_a     = pc_addr;
    instr      = imem_rd;
    unique case (state)
      ST_HOLD: begin
        if (load_start) begin
          next_state = ST_LOAD;
          load_go    = 1'b1;
        end else if (dbg_go) begin
          next_state = ST_DBG;
        end
      end
      ST_LOAD: begin
        s_ready = 1'b1;
        imem_we = s_valid;
        imem_wa = addr_cnt;
        imem_wd = s_data;
        if (s_valid && (s_last || at_end)) next_state = ST_RELEASE;
      end
      ST_RELEASE: next_state = ST_RUN;
      ST_RUN: begin
        cpu_reset = 1'b0;
        if (load_start) begin
          next_state = ST_LOAD;
          load_go    = 1'b1;
          cpu_reset  = 1'b1;
        end else if (dbg_go) begin
          next_state = ST_DBG;
        end
      end
      ST_DBG: begin
        cpu_reset  = !done;
        cpu_stall  = 1'b1;
        imem_a     = dbg_addr;
        instr      = DW'(NOP_INSTR);
        next_state = done ? ST_RUN : ST_HOLD;
      end
      default: next_state = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_HOLD;
      addr_cnt   <= '0;
      word_count <= '0;
      ovf        <= 1'b0;
      done       <= 1'b0;
      dbg_rdata  <= '0;
      dbg_ack    <= 1'b0;
    end else begin
      state   <= next_state;
      dbg_ack <= (state == ST_DBG);
      if (state == ST_DBG) dbg_rdata <= imem_rd;
      if (state == ST_RELEASE) done <= 1'b1;
      if (load_go) begin
        addr_cnt   <= '0;
        word_count <= '0;
        ovf        <= 1'b0;
      end else if (beat) begin
        // The counter only wraps on the final beat of a full load, after which LOAD exits.
        addr_cnt <= addr_cnt + 1'b1;
        if (word_count != (AW+1)'(DEPTH)) word_count <= word_count + 1'b1;
        if (at_end && !s_last) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl with a local combinational-read,
// synchronous-write imem model.
module tb_imem_boot_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;
  logic        s_ready;
  logic        imem_we;
  logic [5:0]  imem_wa;
  logic [31:0] imem_wd;
  logic [5:0]  imem_a;
  logic [31:0] imem_rd;
  logic [5:0]  pc_addr;
  logic [31:0] instr;
  logic        cpu_reset;
  logic        cpu_stall;
  logic        dbg_req;
  logic [5:0]  dbg_addr;
  logic [31:0] dbg_rdata;
  logic        dbg_ack;
  logic        done;
  logic        ovf;
  logic [6:0]  word_count;

  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset
  always #5 clk = ~clk;

  // imem_rw model: preloaded with A5A5_00xx so untouched words are recognisable
  logic [31:0] mem [64];
  logic        preload = 1'b1;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA5A50000 | 32'(i);
    end else if (imem_we) begin
      mem[imem_wa] <= imem_wd;
    end
  end
  assign imem_rd = mem[imem_a];

  imem_boot_ctrl dut (
    .clk(clk), .reset(reset), .load_start(load_start),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .imem_we(imem_we), .imem_wa(imem_wa), .imem_wd(imem_wd),
    .imem_a(imem_a), .imem_rd(imem_rd), .pc_addr(pc_addr), .instr(instr),
    .cpu_reset(cpu_reset), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .done(done), .ovf(ovf), .word_count(word_count)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    reset = 1'b1; load_start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    pc_addr = 6'd5; dbg_req = 1'b0; dbg_addr = '0;
    tick();
    preload = 1'b0;
    tick();
    reset = 1'b0;
    settle();
    n_tests++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
    n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    n_tests++; if ({imem_we, imem_wa, imem_wd} !== 39'd0) begin n_fail++; $display("FAIL reset_write_port: got %b/%h/%h want 0/0/0", imem_we, imem_wa, imem_wd); end
    n_tests++; if (imem_a !== 6'd5) begin n_fail++; $display("FAIL reset_imem_a: got %0d want 5", imem_a); end
    n_tests++; if (instr !== 32'hA5A50005) begin n_fail++; $display("FAIL reset_instr: got %h want a5a50005", instr); end
    n_tests++; if ({cpu_stall, dbg_ack, done, ovf} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got stall/ack/done/ovf=%b want 0000", {cpu_stall, dbg_ack, done, ovf}); end
    n_tests++; if (dbg_rdata !== 32'd0 || word_count !== 7'd0) begin n_fail++; $display("FAIL reset_regs: got rdata=%h wc=%0d want 0/0", dbg_rdata, word_count); end
    tick();
    n_tests++; if (cpu_reset !== 1'b1 || s_ready !== 1'b0) begin n_fail++; $display("FAIL hold_idle: got cpu_reset=%b s_ready=%b want 1/0", cpu_reset, s_ready); end
  endtask

  task automatic test_load4();
    int edges;
    pulse_load();
    edges = 1;
    n_tests++; if (s_ready !== 1'b1 || cpu_reset !== 1'b1) begin n_fail++; $display("FAIL load4_enter: got s_ready=%b cpu_reset=%b want 1/1", s_ready, cpu_reset); end
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 32'h11111111 * 32'(i); s_last = (i == 3);
      settle();
      n_tests++; if (imem_we !== 1'b1 || imem_wa !== 6'(i) || imem_wd !== s_data) begin n_fail++; $display("FAIL load4_wport%0d: got we=%b wa=%0d wd=%h want 1/%0d/%h", i, imem_we, imem_wa, imem_wd, i, s_data); end
      tick();
      edges++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    settle();
    n_tests++; if (cpu_reset !== 1'b1 || s_ready !== 1'b0) begin n_fail++; $display("FAIL load4_release: got cpu_reset=%b s_ready=%b want 1/0", cpu_reset, s_ready); end
    tick();
    edges++;
    n_tests++; if (cpu_reset !== 1'b0 || edges !== 6) begin n_fail++; $display("FAIL load4_cpu_reset_fall: got cpu_reset=%b after %0d edges want 0 after 6", cpu_reset, edges); end
    n_tests++; if (mem[0] !== 32'h0 || mem[1] !== 32'h11111111 || mem[2] !== 32'h22222222 || mem[3] !== 32'h33333333) begin n_fail++; $display("FAIL load4_mem: got %h %h %h %h want 00000000 11111111 22222222 33333333", mem[0], mem[1], mem[2], mem[3]); end
    n_tests++; if (word_count !== 7'd4 || ovf !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL load4_status: got wc=%0d ovf=%b done=%b want 4/0/1", word_count, ovf, done); end
  endtask

  task automatic test_run_fetch();
    pc_addr = 6'd2;
    settle();
    n_tests++; if (instr !== 32'h22222222 || cpu_stall !== 1'b0 || imem_a !== 6'd2) begin n_fail++; $display("FAIL run_fetch: got instr=%h stall=%b a=%0d want 22222222/0/2", instr, cpu_stall, imem_a); end
  endtask

  task automatic test_dbg_read();
    dbg_req = 1'b1; dbg_addr = 6'd1; pc_addr = 6'd3;
    settle();
    n_tests++; if (cpu_stall !== 1'b0 || instr !== 32'h33333333) begin n_fail++; $display("FAIL dbg_pre: got stall=%b instr=%h want 0/33333333", cpu_stall, instr); end
    tick();
    n_tests++; if (cpu_stall !== 1'b1 || imem_a !== 6'd1 || instr !== 32'h0 || dbg_ack !== 1'b0 || cpu_reset !== 1'b0) begin n_fail++; $display("FAIL dbg_cycle: got stall=%b a=%0d instr=%h ack=%b rst=%b want 1/1/00000000/0/0", cpu_stall, imem_a, instr, dbg_ack, cpu_reset); end
    tick();
    n_tests++; if (dbg_ack !== 1'b1 || dbg_rdata !== 32'h11111111 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL dbg_ack: got ack=%b rdata=%h stall=%b want 1/11111111/0", dbg_ack, dbg_rdata, cpu_stall); end
    n_tests++; if (instr !== 32'h33333333) begin n_fail++; $display("FAIL dbg_instr_back: got %h want 33333333", instr); end
    tick();
    n_tests++; if (cpu_stall !== 1'b0 || dbg_ack !== 1'b0) begin n_fail++; $display("FAIL dbg_no_reserve: got stall=%b ack=%b want 0/0", cpu_stall, dbg_ack); end
    dbg_req = 1'b0;
    tick();
    n_tests++; if (cpu_stall !== 1'b0 || dbg_ack !== 1'b0 || dbg_rdata !== 32'h11111111) begin n_fail++; $display("FAIL dbg_idle: got stall=%b ack=%b rdata=%h want 0/0/11111111", cpu_stall, dbg_ack, dbg_rdata); end
  endtask

  task automatic test_overflow();
    int accepted = 0;
    pulse_load();
    n_tests++; if (ovf !== 1'b0 || word_count !== 7'd0) begin n_fail++; $display("FAIL ovf_clear_on_start: got ovf=%b wc=%0d want 0/0", ovf, word_count); end
    for (int i = 0; i < 65; i++) begin
      s_valid = 1'b1; s_data = 32'hC0DE0000 | 32'(i); s_last = 1'b0;
      settle();
      if (i == 64) begin
        n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_s_ready_after64: got %b want 0", s_ready); end
      end
      if (s_ready && s_valid) accepted++;
      tick();
    end
    s_valid = 1'b0;
    settle();
    n_tests++; if (accepted !== 64) begin n_fail++; $display("FAIL ovf_accepted: got %0d want 64", accepted); end
    n_tests++; if (ovf !== 1'b1 || word_count !== 7'd64) begin n_fail++; $display("FAIL ovf_status: got ovf=%b wc=%0d want 1/64", ovf, word_count); end
    n_tests++; if (mem[0] !== 32'hC0DE0000 || mem[63] !== 32'hC0DE003F) begin n_fail++; $display("FAIL ovf_mem: got %h %h want c0de0000 c0de003f", mem[0], mem[63]); end
    n_tests++; if (cpu_reset !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL ovf_run: got cpu_reset=%b done=%b want 0/1", cpu_reset, done); end
  endtask

  task automatic test_load_dbg_priority();
    load_start = 1'b1; dbg_req = 1'b1; dbg_addr = 6'd5;
    tick();
    load_start = 1'b0;
    settle();
    n_tests++; if (cpu_reset !== 1'b1 || s_ready !== 1'b1 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL prio_enter_load: got rst=%b rdy=%b stall=%b want 1/1/0", cpu_reset, s_ready, cpu_stall); end
    n_tests++; if (ovf !== 1'b0 || word_count !== 7'd0) begin n_fail++; $display("FAIL prio_clear: got ovf=%b wc=%0d want 0/0", ovf, word_count); end
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_data = 32'hAAAA0000 | 32'(i); s_last = (i == 1);
      settle();
      n_tests++; if (dbg_ack !== 1'b0 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL prio_no_ack_load%0d: got ack=%b stall=%b want 0/0", i, dbg_ack, cpu_stall); end
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    settle();
    n_tests++; if (dbg_ack !== 1'b0 || cpu_reset !== 1'b1) begin n_fail++; $display("FAIL prio_release: got ack=%b rst=%b want 0/1", dbg_ack, cpu_reset); end
    tick();
    n_tests++; if (cpu_reset !== 1'b0 || dbg_ack !== 1'b0 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL prio_run_entry: got rst=%b ack=%b stall=%b want 0/0/0", cpu_reset, dbg_ack, cpu_stall); end
    tick();
    n_tests++; if (cpu_stall !== 1'b1 || imem_a !== 6'd5) begin n_fail++; $display("FAIL prio_dbg_cycle: got stall=%b a=%0d want 1/5", cpu_stall, imem_a); end
    tick();
    n_tests++; if (dbg_ack !== 1'b1 || dbg_rdata !== 32'hC0DE0005) begin n_fail++; $display("FAIL prio_ack: got ack=%b rdata=%h want 1/c0de0005", dbg_ack, dbg_rdata); end
    dbg_req = 1'b0;
    n_tests++; if (word_count !== 7'd2 || mem[1] !== 32'hAAAA0001) begin n_fail++; $display("FAIL prio_load: got wc=%0d mem1=%h want 2/aaaa0001", word_count, mem[1]); end
    tick();
  endtask

  task automatic test_reset_mid_load();
    pulse_load();
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_data = 32'hBEEF0000 | 32'(i); s_last = 1'b0;
      tick();
    end
    s_data = 32'hBEEF0002;
    reset = 1'b1;
    settle();
    n_tests++; if (cpu_reset !== 1'b1 || done !== 1'b0 || s_ready !== 1'b0 || imem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outputs: got rst=%b done=%b rdy=%b we=%b want 1/0/0/0", cpu_reset, done, s_ready, imem_we); end
    n_tests++; if (word_count !== 7'd0 || ovf !== 1'b0 || dbg_ack !== 1'b0) begin n_fail++; $display("FAIL rst_mid_regs: got wc=%0d ovf=%b ack=%b want 0/0/0", word_count, ovf, dbg_ack); end
    tick();
    reset = 1'b0; s_valid = 1'b0;
    tick();
    n_tests++; if (mem[0] !== 32'hBEEF0000 || mem[1] !== 32'hBEEF0001 || mem[2] !== 32'hC0DE0002) begin n_fail++; $display("FAIL rst_mid_mem: got %h %h %h want beef0000 beef0001 c0de0002", mem[0], mem[1], mem[2]); end
    n_tests++; if (cpu_reset !== 1'b1 || done !== 1'b0 || s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_hold: got rst=%b done=%b rdy=%b want 1/0/0", cpu_reset, done, s_ready); end
  endtask

  initial begin
    test_reset();
    test_load4();
    test_run_fetch();
    test_dbg_read();
    test_overflow();
    test_load_dbg_priority();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot-load and access controller for the 64-word instruction memory of the single-cycle MIPS core. Holds the core in reset while a program is streamed into imem over a valid/ready interface, then releases it. During execution it shares the single imem read port between the core's fetch address and a debug readback requester, stalling the core for one cycle per debug read. Sits between the top-level `mips`/`imem` pair and the board/bench loader.

## Interface
- `DEPTH`, 64: imem words; must be a power of two.
- `AW`, 6: word address width, equal to log2(DEPTH).
- `DW`, 32: instruction width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `load_start`  in  1  single-cycle request to (re)load the program.
- `s_valid`  in  1  stream word valid.
- `s_data`  in  DW  stream word.
- `s_last`  in  1  marks the final word of the stream.
- `s_ready`  out  1  stream accept.
- `imem_we`  out  1  imem write enable.
- `imem_wa`  out  AW  imem write address.
- `imem_wd`  out  DW  imem write data.
- `imem_a`  out  AW  imem read address.
- `imem_rd`  in  DW  imem read data; combinational with respect to `imem_a`.
- `pc_addr`  in  AW  core fetch word address.
- `instr`  out  DW  instruction to the core.
- `cpu_reset`  out  1  core reset.
- `cpu_stall`  out  1  freezes the core's PC and register writes.
- `dbg_req`  in  1  level debug read request; held high until ack.
- `dbg_addr`  in  AW  debug read address.
- `dbg_rdata`  out  DW  registered debug read data.
- `dbg_ack`  out  1  one-cycle completion pulse.
- `done`  out  1  a load has completed since reset.
- `ovf`  out  1  the last load filled DEPTH words without `s_last`.
- `word_count`  out  AW+1  words written by the last load (0..DEPTH).

## Operation
States are HOLD, LOAD, RELEASE, RUN and DBG.

- **HOLD** (reset state):
  - `cpu_reset`=1.
  - `load_start` -> LOAD; clears the address counter, `word_count` and `ovf`.
  - `dbg_req` -> DBG.
- **LOAD**:
  - `cpu_reset`=1, `s_ready`=1.
  - `imem_we`=`s_valid`, `imem_wa`=counter, `imem_wd`=`s_data`; all combinational.
  - Each accepted beat increments the counter and `word_count`.
  - Accepting a beat with `s_last`=1 -> RELEASE.
  - Accepting a beat at counter=DEPTH-1 with `s_last`=0 -> RELEASE and sets `ovf`; the word is still written.
  - `load_start` and `dbg_req` are ignored in this state.
- **RELEASE**:
  - `cpu_reset`=1 for this one cycle; sets `done`.
  - Always -> RUN.
- **RUN**:
  - `cpu_reset`=0, `imem_a`=`pc_addr`, `instr`=`imem_rd`.
  - `load_start` -> LOAD, and `cpu_reset` reasserts.
  - Otherwise `dbg_req` -> DBG.
  - `load_start` has priority when both are asserted in the same cycle; the debug request remains pending.
- **DBG** (always one cycle):
  - `imem_a`=`dbg_addr`, `cpu_stall`=1, `instr`=0 (nop).
  - On exit, `dbg_rdata`<=`imem_rd` and `dbg_ack`=1 for the next cycle.
  - Returns to RUN if `done`=1, otherwise to HOLD.
  - No new DBG entry while `dbg_ack` is high, so a held request is not re-served.
- Counter wrap: the address counter is AW bits and never wraps inside one load; `word_count` saturates at DEPTH.
- `done` clears only on reset. `ovf` and `word_count` clear on the next `load_start`.

## Timing
- Reset values: state=HOLD, `cpu_reset`=1, `s_ready`=0, `imem_we`=0, `imem_wa`=0, `imem_wd`=0, `imem_a`=`pc_addr`, `instr`=`imem_rd`, `cpu_stall`=0, `dbg_rdata`=0, `dbg_ack`=0, `done`=0, `ovf`=0, `word_count`=0.
- Stream writes: one word per cycle at full rate. The write takes effect on the same edge that accepts the beat.
- Load of N words: `load_start` edge, then N accept cycles, then 1 RELEASE cycle. `cpu_reset` falls at the edge after RELEASE.
- Debug read latency: request seen in RUN -> 1 DBG cycle -> `dbg_ack` and valid `dbg_rdata` in the following cycle.
  - Total: 2 cycles, during which the core is stalled for exactly 1 cycle.
- Reset mid-LOAD or mid-DBG: immediate return to HOLD with all outputs at reset values. Words already written to imem are not erased.

## Structure
- Shared package `imem_ctrl_pkg`:
  - state enum `imem_ctrl_state_t`;
  - `IMEM_DEPTH`=64, `IMEM_AW`=6, `IMEM_DW`=32;
  - `NOP_INSTR`=32'h00000000.
- No sub-module is required. The bench supplies a writable imem model, `imem_rw`: combinational read, synchronous write.

## Test plan
1. Reset, then `load_start` and a 4-word stream 00000000/11111111/22222222/33333333 with `s_last` on the 4th word.
   - Required: imem[0..3] hold those values, `word_count`=4, `ovf`=0.
   - Required: `cpu_reset` falls 6 cycles after `load_start`, and `done`=1.
2. In RUN, `pc_addr`=2. Required: `instr`=22222222, `cpu_stall`=0.
3. In RUN, `dbg_req` with `dbg_addr`=1.
   - Required: one cycle with `cpu_stall`=1 and `imem_a`=1.
   - Required: next cycle `dbg_ack`=1 and `dbg_rdata`=11111111; then `instr` tracks `pc_addr` again.
4. Stream 65 words without `s_last`. Required: 64 words accepted, `ovf`=1, `word_count`=64, `s_ready`=0 after the 64th beat.
5. In RUN, `load_start` and `dbg_req` in the same cycle.
   - Required: enters LOAD and `cpu_reset`=1; no `dbg_ack` during LOAD.
   - Required: ack arrives 2 cycles after entering RUN again.
6. Assert `reset` after 2 accepted load beats.
   - Required: state HOLD, `cpu_reset`=1, `done`=0.
   - Required: imem[0..1] retain the written data.
